ul4_seq: RTL and testbench
==========================

UL4_SEQ -- requirements
Module: ul4_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the port cmd_valid, input, 1 bit: the upstream command is present.
REQ-004 The block SHALL have the port cmd_ready, output, 1 bit: the block can accept a command.
REQ-005 The block SHALL have the port cmd_a, input, 4 bits: operand A.
REQ-006 The block SHALL have the port cmd_b, input, 4 bits: operand B.
REQ-007 The block SHALL have the port cmd_s, input, 2 bits: operation select (00 AND, 01 OR, 10 XOR, 11 NOT A).
REQ-008 The block SHALL have the port cmd_chain, input, 1 bit: when 1, use the last captured result as operand A in place of cmd_a.
REQ-009 The block SHALL have the port ul_a, output, 4 bits: registered operand A driven to the logic unit's A input.
REQ-010 The block SHALL have the port ul_b, output, 4 bits: registered operand B driven to the logic unit's B input.
REQ-011 The block SHALL have the port ul_s, output, 2 bits: registered select driven to the logic unit's S input.
REQ-012 The block SHALL have the port ul_out, input, 4 bits: the combinational result returned from the logic unit's Out output.
REQ-013 The block SHALL have the port res, output, 4 bits: the captured result.
REQ-014 The block SHALL have the port res_valid, output, 1 bit: res is valid.
REQ-015 The block SHALL have the port res_ready, input, 1 bit: the downstream stage accepts res.
REQ-016 The block SHALL have the port res_zero, output, 1 bit: res equals 4'b0000; qualified by res_valid.
REQ-017 The block SHALL have the port op_count, output, 8 bits: the number of completed result handshakes.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-019 cmd_ready SHALL equal 1 only in IDLE and be a function of state only.
REQ-020 In IDLE, when cmd_valid=1 at an edge, the block SHALL load ul_a (cmd_chain ? last_res : cmd_a), ul_b=cmd_b and ul_s=cmd_s, then go to EXEC.
REQ-021 In IDLE with cmd_valid=0, all registers SHALL hold their values.
REQ-022 EXEC SHALL last exactly one cycle, with ul_a, ul_b and ul_s stable throughout.
REQ-023 At the edge ending EXEC, the block SHALL capture res=ul_out and last_res=ul_out, set res_valid=1 and go to DONE.
REQ-024 Latency SHALL be 2 cycles from the command-accept edge to the first cycle in which res_valid is high.
REQ-025 In DONE, res_valid SHALL be 1, and res and res_zero SHALL be held stable until res_ready=1 is sampled.
REQ-026 At the edge where res_valid=1 and res_ready=1, the block SHALL clear res_valid, increment op_count, and go to IDLE.
REQ-027 op_count SHALL wrap from 255 to 0 without saturating.
REQ-028 res SHALL retain its last value after the handshake.
REQ-029 ul_a, ul_b and ul_s SHALL retain their values outside EXEC.
REQ-030 A new command SHALL NOT be accepted in the same cycle as a result handshake; the minimum command-to-command spacing SHALL be 3 cycles.
REQ-031 With cmd_s=11, ul_b SHALL still be loaded with cmd_b, and the block SHALL NOT alter ul_out.
REQ-032 When cmd_chain=1 and no result has been captured since reset, last_res SHALL be 0000.
REQ-033 res_zero SHALL be combinational, equal to (res==4'b0000).
REQ-034 Any transition not listed above SHALL be a hold.

Reset
REQ-035 When reset=1 at an edge, in any state (including EXEC or DONE), the block SHALL enter IDLE and SHALL NOT complete the in-flight operation.
REQ-036 On that reset, ul_a=0, ul_b=0, ul_s=00, res=0, last_res=0, res_valid=0 and op_count=0.
REQ-037 While in reset, cmd_ready SHALL read 1 (state IDLE).
REQ-038 Reset SHALL take priority over every handshake in the same cycle.

Verification
REQ-039 (AND) A=1010, B=1100, S=00, chain=0 -> res=1000 two cycles after accept, res_zero=0; after handshake op_count=1.
REQ-040 (Chain) After res=1000, issue B=1111, S=10, chain=1 -> ul_a=1000, res=0111.
REQ-041 (Backpressure) Hold res_ready=0 for 5 cycles after a NOT with A=1010 -> res=0101 stable with res_valid=1 and cmd_ready=0 throughout; after res_ready=1, return to IDLE in one edge.
REQ-042 (Zero) A=0101, B=0101, S=10 -> res=0000, res_zero=1.
REQ-043 (Reset mid-op) Assert reset during EXEC -> next cycle in IDLE, res_valid=0, res=0000, op_count=0, and no result is delivered.
REQ-044 (Wrap) Perform 256 back-to-back handshakes with res_ready=1 -> op_count=0, then 1 after the 257th.

Source files
------------

// File: rtl/ul4_seq.sv
// Command sequencer for an external 4-bit logic unit: registers the operands,
// waits one execute cycle, captures the result and holds it until the downstream side accepts it.
module ul4_seq #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [1:0]        cmd_s,
    input  logic              cmd_chain,
    output logic [DATA_W-1:0] ul_a,
    output logic [DATA_W-1:0] ul_b,
    output logic [1:0]        ul_s,
    input  logic [DATA_W-1:0] ul_out,
    output logic [DATA_W-1:0] res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_zero,
    output logic [7:0]        op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              capture;
    logic              handshake;
    logic [DATA_W-1:0] last_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                // No accept here: a new command waits for the IDLE cycle after the handshake.
                if (res_valid && res_ready) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ul_a      <= '0;
            ul_b      <= '0;
            ul_s      <= '0;
            res       <= '0;
            last_res  <= '0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            if (accept) begin
                ul_a <= cmd_chain ? last_res : cmd_a;
                ul_b <= cmd_b;
                ul_s <= cmd_s;
            end
            if (capture) begin
                res       <= ul_out;
                last_res  <= ul_out;
                res_valid <= 1'b1;
            end
            if (handshake) begin
                res_valid <= 1'b0;
                op_count  <= op_count + 8'd1;
            end
        end
    end

    assign res_zero = (res == '0);

endmodule

// File: tb/tb_ul4_seq.sv
// Directed bench for ul4_seq with a behavioural model of the logic unit on the ul_* ports.
module tb_ul4_seq;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [1:0] cmd_s;
    logic       cmd_chain;
    logic [3:0] ul_a;
    logic [3:0] ul_b;
    logic [1:0] ul_s;
    logic [3:0] ul_out;
    logic [3:0] res;
    logic       res_valid;
    logic       res_ready;
    logic       res_zero;
    logic [7:0] op_count;

    int total = 0;
    int bad   = 0;

    ul4_seq dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_s     (cmd_s),
        .cmd_chain (cmd_chain),
        .ul_a      (ul_a),
        .ul_b      (ul_b),
        .ul_s      (ul_s),
        .ul_out    (ul_out),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_zero  (res_zero),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External logic unit
    always_comb begin
        case (ul_s)
            2'b00:   ul_out = ul_a & ul_b;
            2'b01:   ul_out = ul_a | ul_b;
            2'b10:   ul_out = ul_a ^ ul_b;
            default: ul_out = ~ul_a;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [3:0] a, input logic [3:0] b,
                             input logic [1:0] s, input logic chain);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_s     = s;
        cmd_chain = chain;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        cmd_a = 4'hF; cmd_b = 4'hF; cmd_s = 2'b11; cmd_chain = 1'b0;
        step();
        step();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
        total++; if (res !== 4'h0) begin bad++; $display("FAIL rst_res got=%h exp=0", res); end
        total++; if (op_count !== 8'd0) begin bad++; $display("FAIL rst_op_count got=%0d exp=0", op_count); end
        total++; if ({ul_a, ul_b, ul_s} !== 10'd0) begin bad++; $display("FAIL rst_ul got=%h/%h/%h exp=0/0/0", ul_a, ul_b, ul_s); end
        reset     = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        step();
        total++; if (cmd_ready !== 1'b1 || ul_a !== 4'h0) begin bad++; $display("FAIL idle_hold got ready=%b ul_a=%h exp 1/0", cmd_ready, ul_a); end
    endtask

    task automatic test_and();
        drive_cmd(4'b1010, 4'b1100, 2'b00, 1'b0);
        step();
        cmd_valid = 1'b0;
        total++; if ({ul_a, ul_b, ul_s} !== {4'b1010, 4'b1100, 2'b00}) begin bad++; $display("FAIL and_ul got=%b/%b/%b exp=1010/1100/00", ul_a, ul_b, ul_s); end
        total++; if (cmd_ready !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL and_exec got ready=%b valid=%b exp 0/0", cmd_ready, res_valid); end
        step();
        total++; if (res !== 4'b1000 || res_valid !== 1'b1) begin bad++; $display("FAIL and_res got=%b v=%b exp=1000 v=1", res, res_valid); end
        total++; if (res_zero !== 1'b0) begin bad++; $display("FAIL and_zero got=%b exp=0", res_zero); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        total++; if (op_count !== 8'd1 || res_valid !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL and_hs got cnt=%0d v=%b rdy=%b exp 1/0/1", op_count, res_valid, cmd_ready); end
        total++; if (res !== 4'b1000) begin bad++; $display("FAIL and_res_keep got=%b exp=1000", res); end
    endtask

    task automatic test_chain();
        drive_cmd(4'b0000, 4'b1111, 2'b10, 1'b1);
        step();
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        total++; if (ul_a !== 4'b1000) begin bad++; $display("FAIL chain_ul_a got=%b exp=1000", ul_a); end
        step();
        total++; if (res !== 4'b0111 || res_valid !== 1'b1) begin bad++; $display("FAIL chain_res got=%b v=%b exp=0111 v=1", res, res_valid); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        total++; if (op_count !== 8'd2) begin bad++; $display("FAIL chain_cnt got=%0d exp=2", op_count); end
    endtask

    task automatic test_backpressure();
        drive_cmd(4'b1010, 4'b0011, 2'b11, 1'b0);
        step();
        total++; if (ul_b !== 4'b0011 || ul_s !== 2'b11) begin bad++; $display("FAIL not_ul_b got=%b/%b exp=0011/11", ul_b, ul_s); end
        // Keep a competing command present; it must not be taken while busy.
        drive_cmd(4'b0110, 4'b1001, 2'b01, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (res !== 4'b0101 || res_valid !== 1'b1 || cmd_ready !== 1'b0 || ul_a !== 4'b1010) begin
                bad++;
                $display("FAIL bp_hold[%0d] got res=%b v=%b rdy=%b ul_a=%b exp 0101/1/0/1010", i, res, res_valid, cmd_ready, ul_a);
            end
            step();
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        total++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || op_count !== 8'd3) begin bad++; $display("FAIL bp_release got rdy=%b v=%b cnt=%0d exp 1/0/3", cmd_ready, res_valid, op_count); end
        total++; if (ul_a !== 4'b1010 || ul_b !== 4'b0011) begin bad++; $display("FAIL bp_no_accept got ul_a=%b ul_b=%b exp 1010/0011", ul_a, ul_b); end
        cmd_valid = 1'b0;
    endtask

    task automatic test_zero();
        drive_cmd(4'b0101, 4'b0101, 2'b10, 1'b0);
        step();
        cmd_valid = 1'b0;
        step();
        total++; if (res !== 4'b0000 || res_zero !== 1'b1 || res_valid !== 1'b1) begin bad++; $display("FAIL zero got res=%b z=%b v=%b exp 0000/1/1", res, res_zero, res_valid); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        total++; if (op_count !== 8'd4) begin bad++; $display("FAIL zero_cnt got=%0d exp=4", op_count); end
    endtask

    task automatic test_reset_midop();
        drive_cmd(4'b1111, 4'b1111, 2'b00, 1'b0);
        step();
        cmd_valid = 1'b0;
        reset     = 1'b1;
        res_ready = 1'b1;
        step();
        reset = 1'b0;
        total++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res !== 4'h0 || op_count !== 8'd0) begin bad++; $display("FAIL midrst got rdy=%b v=%b res=%b cnt=%0d exp 1/0/0000/0", cmd_ready, res_valid, res, op_count); end
        step();
        step();
        total++; if (res_valid !== 1'b0 || res !== 4'h0 || op_count !== 8'd0) begin bad++; $display("FAIL midrst_nodeliver got v=%b res=%b cnt=%0d exp 0/0000/0", res_valid, res, op_count); end
        // Chaining right after reset uses a cleared last result.
        drive_cmd(4'b1111, 4'b0101, 2'b01, 1'b1);
        step();
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        total++; if (ul_a !== 4'b0000) begin bad++; $display("FAIL chain_after_rst ul_a got=%b exp=0000", ul_a); end
        step();
        total++; if (res !== 4'b0101) begin bad++; $display("FAIL chain_after_rst res got=%b exp=0101", res); end
        step();
        total++; if (op_count !== 8'd1) begin bad++; $display("FAIL chain_after_rst cnt got=%0d exp=1", op_count); end
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        res_ready = 1'b1;
        drive_cmd(4'b0011, 4'b0101, 2'b01, 1'b0);
        repeat (765) @(posedge clk);
        #1;
        total++; if (op_count !== 8'd255 || cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_255 got cnt=%0d rdy=%b exp 255/1", op_count, cmd_ready); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (op_count !== 8'd0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_wrap got cnt=%0d rdy=%b exp 0/1", op_count, cmd_ready); end
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        total++; if (op_count !== 8'd1 || res !== 4'b0111) begin bad++; $display("FAIL b2b_257 got cnt=%0d res=%b exp 1/0111", op_count, res); end
        res_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_s = '0; cmd_chain = 1'b0;
        test_reset();
        test_and();
        test_chain();
        test_backpressure();
        test_zero();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
